// File: rtl/ddr4_axi_upsizer_pkg.sv
// Shared types and helpers for the AXI upsizer write path.
// The command struct is sized for the widest supported ratio.
package ddr4_axi_upsizer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PACK = 1'b1
    } state_t;

    localparam int CMD_LEN_W    = 8;
    localparam int CMD_OFFSET_W = 4;

    typedef struct packed {
        logic [CMD_OFFSET_W-1:0] offset;
        logic [CMD_LEN_W-1:0]    len;
        logic                    fix;
    } cmd_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/ddr4_axi_upsizer_w_packer_if.sv
// Command, narrow-W and wide-W channels of the upsizer write packer.
// "slave" is the packer's view; "master" is the view of whatever drives it.
interface ddr4_axi_upsizer_w_packer_if #(
    parameter int C_S_DATA_WIDTH = 32,
    parameter int C_M_DATA_WIDTH = 128
);
    localparam int C_RATIO_LOG = ddr4_axi_upsizer_pkg::clog2(C_M_DATA_WIDTH / C_S_DATA_WIDTH);

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [C_RATIO_LOG-1:0]      cmd_offset;
    logic [7:0]                  cmd_len;
    logic                        cmd_fix;

    logic [C_S_DATA_WIDTH-1:0]   s_wdata;
    logic [C_S_DATA_WIDTH/8-1:0] s_wstrb;
    logic                        s_wlast;
    logic                        s_wvalid;
    logic                        s_wready;

    logic [C_M_DATA_WIDTH-1:0]   m_wdata;
    logic [C_M_DATA_WIDTH/8-1:0] m_wstrb;
    logic                        m_wlast;
    logic                        m_wvalid;
    logic                        m_wready;

    modport slave (
        input  cmd_valid, cmd_offset, cmd_len, cmd_fix,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid, m_wready,
        output cmd_ready, s_wready, m_wdata, m_wstrb, m_wlast, m_wvalid
    );

    modport master (
        output cmd_valid, cmd_offset, cmd_len, cmd_fix,
        output s_wdata, s_wstrb, s_wlast, s_wvalid, m_wready,
        input  cmd_ready, s_wready, m_wdata, m_wstrb, m_wlast, m_wvalid
    );

endinterface

// File: rtl/ddr4_axi_upsizer_w_packer.sv
// Packs narrow W beats into wide W words using per-burst offset/len/fix
// from the AW path; one registered output slot decouples S and M handshakes.
module ddr4_axi_upsizer_w_packer
    import ddr4_axi_upsizer_pkg::*;
#(
    parameter string C_FAMILY       = "virtex6",
    parameter int    C_S_DATA_WIDTH = 32,
    parameter int    C_M_DATA_WIDTH = 128
) (
    input logic                        clk,
    input logic                        rst,
    ddr4_axi_upsizer_w_packer_if.slave bus
);

    localparam int C_RATIO     = C_M_DATA_WIDTH / C_S_DATA_WIDTH;
    localparam int C_RATIO_LOG = clog2(C_RATIO);
    localparam int S_STRB_W    = C_S_DATA_WIDTH / 8;
    localparam int M_STRB_W    = C_M_DATA_WIDTH / 8;

    state_t                  state, state_nx;
    logic                    cmd_ready;
    logic [C_RATIO_LOG-1:0]  lane_ptr;
    logic [7:0]              beat_cnt;
    logic                    fix;
    logic [C_M_DATA_WIDTH-1:0] acc_data, merged_data, m_wdata;
    logic [M_STRB_W-1:0]     acc_strb, merged_strb, m_wstrb;
    logic                    m_wlast, m_wvalid;
    logic                    s_wready, s_fire, cmd_fire, last_beat, word_done;

    assign last_beat = (beat_cnt == 8'd0);
    assign s_wready  = (state == PACK) && (!m_wvalid || bus.m_wready);
    assign s_fire    = bus.s_wvalid && s_wready;
    assign cmd_fire  = bus.cmd_valid && cmd_ready;
    assign word_done = (lane_ptr == C_RATIO_LOG'(C_RATIO - 1)) || last_beat || fix;

    // Accumulator with the current beat dropped into its lane.
    always_comb begin
        merged_data = acc_data;
        merged_strb = acc_strb;
        for (int i = 0; i < C_RATIO; i++) begin
            if (lane_ptr == C_RATIO_LOG'(i)) begin
                merged_data[i*C_S_DATA_WIDTH +: C_S_DATA_WIDTH] = bus.s_wdata;
                merged_strb[i*S_STRB_W +: S_STRB_W]             = bus.s_wstrb;
            end
        end
    end

    // IDLE | waiting for a burst command;  PACK | merging the burst's beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) state_nx = PACK;
            end
            PACK: begin
                if (s_fire && last_beat) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_ptr <= '0;
            beat_cnt <= '0;
            fix      <= 1'b0;
            acc_data <= '0;
            acc_strb <= '0;
            m_wdata  <= '0;
            m_wstrb  <= '0;
            m_wlast  <= 1'b0;
            m_wvalid <= 1'b0;
        end else begin
            if (cmd_fire) begin
                lane_ptr <= bus.cmd_offset;
                beat_cnt <= bus.cmd_len;
                fix      <= bus.cmd_fix;
                acc_data <= '0;
                acc_strb <= '0;
            end
            if (s_fire) begin
                beat_cnt <= beat_cnt - 8'd1;
                if (!fix) lane_ptr <= lane_ptr + 1'b1;
                if (word_done) begin
                    m_wdata  <= merged_data;
                    m_wstrb  <= merged_strb;
                    m_wlast  <= last_beat;
                    acc_data <= '0;
                    acc_strb <= '0;
                end else begin
                    acc_data <= merged_data;
                    acc_strb <= merged_strb;
                end
            end
            // A load in the same cycle as a drain keeps the slot full.
            if (s_fire && word_done) m_wvalid <= 1'b1;
            else if (bus.m_wready)   m_wvalid <= 1'b0;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.s_wready  = s_wready;
    assign bus.m_wdata   = m_wdata;
    assign bus.m_wstrb   = m_wstrb;
    assign bus.m_wlast   = m_wlast;
    assign bus.m_wvalid  = m_wvalid;

    a_wlast_matches_len: assert property (@(posedge clk) disable iff (rst)
        s_fire |-> (bus.s_wlast == last_beat))
        else $error("%s packer: S WLAST disagrees with command length", C_FAMILY);

endmodule

// File: doc/ddr4_axi_upsizer_w_packer.md
Name: ddr4_axi_upsizer_w_packer

Overview:
- Write-data packing stage of the AXI upsizer. Sits downstream of the AW command path, which supplies per-burst lane offset, length and burst-type information.
- Accepts narrow S-side W beats and merges them into wide M-side W words with correct byte strobes.
- Emits a wide word when the lane pointer wraps, on the final beat of a burst, or on every beat for FIXED bursts.
- A single registered output slot decouples the S-side and M-side handshakes.

Parameters:
- C_FAMILY, "virtex6", FPGA family passed through for consistency with sibling upsizer blocks.
- C_S_DATA_WIDTH, 32, narrow slave data width in bits (32/64/128).
- C_M_DATA_WIDTH, 128, wide master data width in bits; must be a power-of-two multiple of C_S_DATA_WIDTH, ratio ≥2.
- Derived localparams: C_RATIO = C_M_DATA_WIDTH/C_S_DATA_WIDTH; C_RATIO_LOG = log2(C_RATIO).

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  burst command valid.
- CMD_READY  out  1  command accepted when VALID&READY.
- CMD_OFFSET  in  C_RATIO_LOG  starting lane of the first beat.
- CMD_LEN  in  8  beats minus 1 (AXI AWLEN).
- CMD_FIX  in  1  1 = FIXED burst: every beat goes to CMD_OFFSET and forms its own wide word.
- S_AXI_WDATA  in  C_S_DATA_WIDTH  narrow write data.
- S_AXI_WSTRB  in  C_S_DATA_WIDTH/8  narrow strobes.
- S_AXI_WLAST  in  1  ignored for framing (CMD_LEN governs); used only for an assertion.
- S_AXI_WVALID  in  1
- S_AXI_WREADY  out  1
- M_AXI_WDATA  out  C_M_DATA_WIDTH  packed wide data.
- M_AXI_WSTRB  out  C_M_DATA_WIDTH/8  packed strobes.
- M_AXI_WLAST  out  1  set on the wide word holding the final narrow beat.
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1

Behaviour:
- States are IDLE and PACK.
  - IDLE: CMD_READY=1. On CMD_VALID, latch lane_ptr←CMD_OFFSET, beat_cnt←CMD_LEN and fix←CMD_FIX, clear acc_strb, then go to PACK.
  - PACK: CMD_READY=0.
- S_AXI_WREADY = (state==PACK) && (!M_AXI_WVALID || M_AXI_WREADY). This allows one narrow beat per cycle under a full-throughput M side.
- On an accepted narrow beat:
  - Write the data and strobe into lane lane_ptr of the accumulator.
  - The beat completes the word when (lane_ptr==C_RATIO-1) || (beat_cnt==0) || fix.
- On completion:
  - The output register loads accumulator|current beat in the same edge.
  - M_AXI_WVALID=1 from the next cycle, so latency from the completing S handshake to M_AXI_WVALID is 1 cycle.
  - Unwritten lanes carry strobe 0 and data 0.
  - acc_strb clears; M_AXI_WLAST=(beat_cnt==0).
- Pointer update:
  - Non-fix: lane_ptr increments and wraps modulo C_RATIO.
  - Fix: lane_ptr holds at the offset.
  - beat_cnt decrements on every accepted beat.
- When beat_cnt==0 is accepted, return to IDLE. A new command may be accepted in IDLE while the final wide word is still pending on M; the next burst's beats stall through S_AXI_WREADY until the slot frees.
- M_AXI_WDATA, M_AXI_WSTRB and M_AXI_WLAST stay stable while M_AXI_WVALID=1 && !M_AXI_WREADY.
- Reset (asserted at any time, including mid-burst) asynchronously clears:
  - state→IDLE, M_AXI_WVALID=0, M_AXI_WLAST=0;
  - M_AXI_WSTRB=0, M_AXI_WDATA=0, acc_strb=0;
  - lane_ptr=0, beat_cnt=0.
  
  Outputs after release: CMD_READY=1, S_AXI_WREADY=0. The partially packed data is discarded.
- Simultaneous events: the output-slot drain (M handshake) and a load (S completion) in the same cycle are legal; the new word wins and M_AXI_WVALID stays 1.
- Simulation assertion: S_AXI_WLAST==(beat_cnt==0) on every accepted beat.

Decomposition:
- Package ddr4_axi_upsizer_pkg holds:
  - the state enum (IDLE, PACK);
  - a function clog2 for C_RATIO_LOG;
  - the command struct {offset, len, fix} shared with the AW command FIFO.
- No sub-module is required; lane-completion detection is a few bits and stays inline.

Test Plan:
1. Ratio 4: cmd offset 0, len 3, beats 0x11111111/0x22222222/0x33333333/0x44444444, full strobes, M_WREADY=1 → one wide word 0x44444444_33333333_22222222_11111111, WSTRB 0xFFFF, WLAST=1, appearing 1 cycle after the 4th beat.
2. Cmd offset 2, len 3 → word0 WSTRB 0xFF00 with WLAST=0; word1 WSTRB 0x00FF with WLAST=1; lanes are in the correct positions.
3. Cmd fix=1, offset 1, len 1, two beats → two words, each WSTRB 0x00F0, data in bits [63:32]; WLAST only on the second.
4. Cmd offset 0, len 7, M_WREADY low for 5 cycles after the first word → S_AXI_WREADY=0 during the stall, M data/strobe held constant, no beat lost, second word correct.
5. Cmd offset 3, len 0, narrow WSTRB 0x5 → single word WSTRB 0x5000, WLAST=1, FSM back in IDLE; CMD_READY=1 the next cycle.
6. ARESET pulsed after 2 of 4 beats → M_AXI_WVALID=0 immediately; after release CMD_READY=1, and a fresh len-0 burst produces a word with only its own strobes set.
